// File: rtl/axil_ram_slave.sv
// AXI-Lite subordinate backed by a word-organised RAM with byte strobes.
// Independent write and read paths, one outstanding transaction on each.
module axil_ram_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int MEM_DEPTH  = 1024,
   parameter int IDX_WIDTH  = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]            s_axil_awprot,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready
);

   localparam logic [1:0] WR_IDLE = 2'd0;
   localparam logic [1:0] WR_HOLD = 2'd1;
   localparam logic [1:0] WR_RESP = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [ADDR_WIDTH-1:0] DEPTH_LIM = ADDR_WIDTH'(MEM_DEPTH);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [1:0]            wr_state_q, wr_state_d;
   logic                  aw_held_q, aw_held_d;
   logic                  w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  bvalid;
   logic                  aw_hs, w_hs, ar_hs;
   logic                  wr_commit, mem_we;
   logic                  aw_in_range, ar_in_range;
   logic [IDX_WIDTH-1:0]  wr_idx, rd_idx;
   logic                  unused_bits;

   assign unused_bits = ^{s_axil_awprot, s_axil_arprot, awaddr_q[1:0], s_axil_araddr[1:0]};

   always_comb begin
      bvalid         = (wr_state_q == WR_RESP);
      s_axil_awready = rstn & ~aw_held_q & ~bvalid;
      s_axil_wready  = rstn & ~w_held_q & ~bvalid;
      s_axil_arready = rstn & ~rvalid_q;
      s_axil_bvalid  = bvalid;
      s_axil_bresp   = bresp_q;
      s_axil_rvalid  = rvalid_q;
      s_axil_rresp   = rresp_q;
      s_axil_rdata   = rdata_q;

      aw_hs = s_axil_awvalid & s_axil_awready;
      w_hs  = s_axil_wvalid & s_axil_wready;
      ar_hs = s_axil_arvalid & s_axil_arready;

      // Range test on the full word address so aliasing upper bits never hit the array.
      aw_in_range = ({2'b00, awaddr_q[ADDR_WIDTH-1:2]} < DEPTH_LIM);
      ar_in_range = ({2'b00, s_axil_araddr[ADDR_WIDTH-1:2]} < DEPTH_LIM);
      wr_idx      = awaddr_q[IDX_WIDTH+1:2];
      rd_idx      = s_axil_araddr[IDX_WIDTH+1:2];

      wr_commit = aw_held_q & w_held_q;
      mem_we    = rstn & wr_commit & aw_in_range;
   end

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;

      case (wr_state_q)
         WR_RESP: begin
            if (s_axil_bready) wr_state_d = WR_IDLE;
         end
         default: begin
            if (wr_commit) begin
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               bresp_d    = aw_in_range ? RESP_OKAY : RESP_SLVERR;
               wr_state_d = WR_RESP;
            end else begin
               if (aw_hs) begin
                  aw_held_d = 1'b1;
                  awaddr_d  = s_axil_awaddr;
               end
               if (w_hs) begin
                  w_held_d = 1'b1;
                  wdata_d  = s_axil_wdata;
                  wstrb_d  = s_axil_wstrb;
               end
               wr_state_d = (aw_held_d | w_held_d) ? WR_HOLD : WR_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
         rdata_d  = ar_in_range ? mem[rd_idx] : '0;
      end else if (rvalid_q & s_axil_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_state_q <= WR_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= '0;
         rvalid_q   <= 1'b0;
         rresp_q    <= '0;
         rdata_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   // Array has no reset; a read on the commit edge sees the pre-write word.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb_q[b]) mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

endmodule
